// File: rtl/fwft_fifo.sv
// Synchronous FIFO with standard (registered) or first-word-fall-through read.
// Sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fwft_fifo #(
    parameter int WIDTH                = 72,
    parameter int MAX_DEPTH_BITS       = 3,
    parameter int PROG_FULL_THRESHOLD  = (2 ** MAX_DEPTH_BITS) - 1,
    parameter int PROG_EMPTY_THRESHOLD = 1,
    parameter int FWFT                 = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          din_i,
    input  logic                      wr_en_i,
    input  logic                      rd_en_i,
    output logic [WIDTH-1:0]          dout_o,
    output logic                      dout_valid_o,
    output logic                      full_o,
    output logic                      nearly_full_o,
    output logic                      prog_full_o,
    output logic                      empty_o,
    output logic                      prog_empty_o,
    output logic [MAX_DEPTH_BITS:0]   data_count_o,
    input  logic                      err_clr_i,
    output logic                      overflow_o,
    output logic                      underflow_o
);

    localparam int MAX_DEPTH = 2 ** MAX_DEPTH_BITS;
    localparam int PTR_W     = MAX_DEPTH_BITS;
    localparam int CNT_W     = MAX_DEPTH_BITS + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_DEPTH);
    localparam logic [CNT_W-1:0] CNT_NFULL = CNT_W'(MAX_DEPTH - 1);
    localparam logic [CNT_W-1:0] PF_TH     = CNT_W'(PROG_FULL_THRESHOLD);
    localparam logic [CNT_W-1:0] PE_TH     = CNT_W'(PROG_EMPTY_THRESHOLD);

    logic [WIDTH-1:0] mem_q [MAX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] store_cnt;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dval_q, dval_d;

    logic empty;
    logic full;
    logic rd_acc;
    logic wr_acc;
    logic pop;

    // In FWFT mode cnt_q also counts the word parked in the output register.
    assign store_cnt = cnt_q - CNT_W'(dval_q);
    assign full      = (cnt_q == CNT_FULL);
    assign empty     = (FWFT != 0) ? !dval_q : (cnt_q == '0);
    assign rd_acc    = rd_en_i && !empty;
    assign wr_acc    = wr_en_i && (!full || rd_acc);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        dout_d   = dout_q;
        dval_d   = dval_q;
        pop      = 1'b0;
        if (FWFT != 0) begin
            pop = (store_cnt != '0) && (!dval_q || rd_acc);
            if (pop) begin
                dout_d = mem_q[rd_ptr_q];
                dval_d = 1'b1;
            end else if (rd_acc) begin
                dval_d = 1'b0;
            end
        end else begin
            pop    = rd_acc;
            dval_d = rd_acc;
            if (rd_acc) begin
                dout_d = mem_q[rd_ptr_q];
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        cnt_d = cnt_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            dval_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            dval_q   <= dval_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o        = dout_q;
    assign dout_valid_o  = dval_q;
    assign full_o        = full;
    assign nearly_full_o = (cnt_q >= CNT_NFULL);
    assign prog_full_o   = (cnt_q >= PF_TH);
    assign empty_o       = empty;
    assign prog_empty_o  = (cnt_q <= PE_TH);
    assign data_count_o  = cnt_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // A new error wins over a simultaneous clear.
    always_comb begin
        ovf_d = (ovf_q && !err_clr_i) || (wr_en_i && !wr_acc);
        udf_d = (udf_q && !err_clr_i) || (rd_en_i && !rd_acc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign overflow_o     = 1'b0;
    assign underflow_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fwft_fifo.sv
// Directed scoreboard bench: one standard-mode and one FWFT-mode fwft_fifo.
// Expected error-flag values follow whether FIFO_ERR_FLAGS_EN is defined.
module tb_fwft_fifo;

    localparam int W = 8;

`ifdef FIFO_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [W-1:0] s_din, s_dout;
    logic s_wr, s_rd, s_clr, s_dval, s_full, s_nfull, s_pfull;
    logic s_empty, s_pempty, s_ovf, s_udf;
    logic [3:0] s_cnt;

    logic [W-1:0] f_din, f_dout;
    logic f_wr, f_rd, f_clr, f_dval, f_full, f_nfull, f_pfull;
    logic f_empty, f_pempty, f_ovf, f_udf;
    logic [3:0] f_cnt;

    fwft_fifo #(
        .WIDTH(W), .MAX_DEPTH_BITS(3),
        .PROG_FULL_THRESHOLD(6), .PROG_EMPTY_THRESHOLD(2), .FWFT(0)
    ) u_std (
        .clk(clk), .reset(reset), .din_i(s_din), .wr_en_i(s_wr),
        .rd_en_i(s_rd), .dout_o(s_dout), .dout_valid_o(s_dval),
        .full_o(s_full), .nearly_full_o(s_nfull), .prog_full_o(s_pfull),
        .empty_o(s_empty), .prog_empty_o(s_pempty), .data_count_o(s_cnt),
        .err_clr_i(s_clr), .overflow_o(s_ovf), .underflow_o(s_udf)
    );

    fwft_fifo #(
        .WIDTH(W), .MAX_DEPTH_BITS(3), .FWFT(1)
    ) u_fw (
        .clk(clk), .reset(reset), .din_i(f_din), .wr_en_i(f_wr),
        .rd_en_i(f_rd), .dout_o(f_dout), .dout_valid_o(f_dval),
        .full_o(f_full), .nearly_full_o(f_nfull), .prog_full_o(f_pfull),
        .empty_o(f_empty), .prog_empty_o(f_pempty), .data_count_o(f_cnt),
        .err_clr_i(f_clr), .overflow_o(f_ovf), .underflow_o(f_udf)
    );

    int passes = 0;
    int total  = 0;
    logic [W-1:0] sq[$];
    logic [W-1:0] fq[$];
    logic [W-1:0] exp_w;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        s_din = '0; s_wr = 0; s_rd = 0; s_clr = 0;
        f_din = '0; f_wr = 0; f_rd = 0; f_clr = 0;
        step();
        step();
        reset = 1'b0;

        chk("s_empty_rst", s_empty, 1);
        chk("s_full_rst", s_full, 0);
        chk("s_cnt_rst", s_cnt, 0);
        chk("s_dval_rst", s_dval, 0);
        chk("s_dout_rst", s_dout, 0);
        chk("s_pempty_rst", s_pempty, 1);
        chk("s_pfull_rst", s_pfull, 0);
        chk("f_empty_rst", f_empty, 1);
        chk("f_dval_rst", f_dval, 0);
        chk("f_ovf_rst", f_ovf, 0);
        chk("f_udf_rst", f_udf, 0);

        // standard mode: fill, thresholds, full
        s_wr = 1;
        for (int i = 1; i <= 8; i++) begin
            s_din = W'(i);
            step();
            sq.push_back(W'(i));
            chk("s_cnt_fill", s_cnt, i);
            chk("s_pfull", s_pfull, (i >= 6));
            chk("s_nfull", s_nfull, (i >= 7));
            chk("s_pempty", s_pempty, (i <= 2));
        end
        s_wr = 0;
        chk("s_full", s_full, 1);

        s_din = 8'h55; s_wr = 1;
        step();
        s_wr = 0;
        chk("s_cnt_drop", s_cnt, 8);
        chk("s_ovf", s_ovf, ERR_EN);
        chk("s_dval_idle", s_dval, 0);

        s_rd = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_w = sq.pop_front();
            chk("s_dval_rd", s_dval, 1);
            chk("s_dout_rd", s_dout, exp_w);
        end
        s_rd = 0;
        chk("s_empty_end", s_empty, 1);
        chk("s_cnt_end", s_cnt, 0);
        step();
        chk("s_dval_drop", s_dval, 0);
        chk("s_dout_hold", s_dout, exp_w);

        s_rd = 1;
        step();
        s_rd = 0;
        chk("s_dval_ign", s_dval, 0);
        chk("s_dout_ign", s_dout, exp_w);
        chk("s_cnt_ign", s_cnt, 0);
        chk("s_udf", s_udf, ERR_EN);
        chk("s_ovf_sticky", s_ovf, ERR_EN);

        s_clr = 1;
        step();
        s_clr = 0;
        chk("s_ovf_clr", s_ovf, 0);
        chk("s_udf_clr", s_udf, 0);

        // write and read together on empty: write wins, read ignored
        s_din = 8'h3C; s_wr = 1; s_rd = 1;
        step();
        s_wr = 0; s_rd = 0;
        sq.push_back(8'h3C);
        chk("s_cnt_wr_rd_empty", s_cnt, 1);
        chk("s_dval_wr_rd_empty", s_dval, 0);
        chk("s_udf_wr_rd_empty", s_udf, ERR_EN);
        s_rd = 1;
        step();
        s_rd = 0;
        exp_w = sq.pop_front();
        chk("s_dval_3c", s_dval, 1);
        chk("s_dout_3c", s_dout, exp_w);

        // clear and new error in the same cycle
        s_clr = 1; s_rd = 1;
        step();
        s_rd = 0;
        chk("s_udf_clr_err", s_udf, ERR_EN);
        step();
        s_clr = 0;
        chk("s_udf_clr2", s_udf, 0);

        // FWFT: single word latency
        f_din = 8'hA5; f_wr = 1;
        step();
        f_wr = 0;
        fq.push_back(8'hA5);
        chk("f_cnt_one", f_cnt, 1);
        chk("f_dval_lag", f_dval, 0);
        chk("f_empty_lag", f_empty, 1);
        step();
        chk("f_dval_one", f_dval, 1);
        chk("f_empty_one", f_empty, 0);
        exp_w = fq.pop_front();
        chk("f_dout_a5", f_dout, exp_w);
        f_rd = 1;
        step();
        f_rd = 0;
        chk("f_dval_pop", f_dval, 0);
        chk("f_cnt_pop", f_cnt, 0);
        chk("f_empty_pop", f_empty, 1);

        // FWFT: fill to full
        f_wr = 1;
        for (int i = 0; i < 8; i++) begin
            f_din = W'(8'h10 + i);
            step();
            fq.push_back(f_din);
        end
        f_wr = 0;
        chk("f_full", f_full, 1);
        chk("f_cnt_full", f_cnt, 8);

        f_din = 8'h55; f_wr = 1;
        step();
        f_wr = 0;
        chk("f_cnt_drop", f_cnt, 8);
        chk("f_ovf", f_ovf, ERR_EN);
        chk("f_dout_head", f_dout, fq[0]);

        // FWFT: sustained write+read while full, across pointer wrap
        f_wr = 1; f_rd = 1;
        for (int i = 0; i < 20; i++) begin
            f_din = W'(8'h20 + i);
            exp_w = fq.pop_front();
            chk("f_stream_dval", f_dval, 1);
            chk("f_stream_dout", f_dout, exp_w);
            fq.push_back(f_din);
            step();
            chk("f_stream_cnt", f_cnt, 8);
            chk("f_stream_full", f_full, 1);
        end
        f_wr = 0;

        for (int n = 0; n < 16 && fq.size() > 0; n++) begin
            exp_w = fq.pop_front();
            chk("f_drain_dval", f_dval, 1);
            chk("f_drain_dout", f_dout, exp_w);
            step();
        end
        f_rd = 0;
        chk("f_empty_drain", f_empty, 1);
        chk("f_cnt_drain", f_cnt, 0);
        chk("f_udf_none", f_udf, 0);

        f_din = 8'h66; f_wr = 1; f_rd = 1;
        step();
        f_wr = 0; f_rd = 0;
        fq.push_back(8'h66);
        chk("f_cnt_wr_rd_empty", f_cnt, 1);
        chk("f_dval_wr_rd_empty", f_dval, 0);
        chk("f_udf", f_udf, ERR_EN);
        step();
        chk("f_dval_66", f_dval, 1);
        chk("f_dout_66", f_dout, fq[0]);

        // reset mid-burst with requests asserted
        s_wr = 1;
        for (int i = 0; i < 6; i++) begin
            s_din = W'(8'h40 + i);
            step();
            sq.push_back(s_din);
        end
        s_wr = 0; s_rd = 1;
        step();
        s_rd = 0;
        exp_w = sq.pop_front();
        chk("s_dout_pre_rst", s_dout, exp_w);
        chk("s_cnt_pre_rst", s_cnt, 5);

        reset = 1;
        s_din = 8'h99; s_wr = 1; s_rd = 1;
        f_din = 8'h99; f_wr = 1; f_rd = 1;
        step();
        reset = 0;
        s_wr = 0; s_rd = 0; f_wr = 0; f_rd = 0;
        sq.delete();
        fq.delete();
        chk("s_cnt_rst2", s_cnt, 0);
        chk("s_dout_rst2", s_dout, 0);
        chk("s_dval_rst2", s_dval, 0);
        chk("s_empty_rst2", s_empty, 1);
        chk("f_cnt_rst2", f_cnt, 0);
        chk("f_dout_rst2", f_dout, 0);
        chk("f_dval_rst2", f_dval, 0);
        chk("f_empty_rst2", f_empty, 1);
        chk("f_udf_rst2", f_udf, 0);

        s_din = 8'h77; s_wr = 1;
        f_din = 8'h88; f_wr = 1;
        step();
        s_wr = 0; f_wr = 0;
        sq.push_back(8'h77);
        fq.push_back(8'h88);
        chk("s_cnt_post", s_cnt, 1);
        chk("f_dval_post_lag", f_dval, 0);
        s_rd = 1;
        step();
        s_rd = 0;
        exp_w = sq.pop_front();
        chk("s_dval_post", s_dval, 1);
        chk("s_dout_post", s_dout, exp_w);
        chk("s_cnt_post0", s_cnt, 0);
        exp_w = fq.pop_front();
        chk("f_dval_post", f_dval, 1);
        chk("f_dout_post", f_dout, exp_w);
        f_rd = 1;
        step();
        f_rd = 0;
        chk("f_dval_post_pop", f_dval, 0);
        chk("f_cnt_post_pop", f_cnt, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
